// File: rtl/porta_entrada.sv
// Memory-mapped input port: producer bytes enter a small FIFO through valid/ready,
// and the processor pops them or reads a status byte with registered read data.
module porta_entrada #(
    parameter logic [7:0]  ADDR_DADO   = 8'hF0,
    parameter logic [7:0]  ADDR_STATUS = 8'hF1,
    parameter int unsigned DEPTH       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] entrada,
    input  logic       entrada_valid,
    output logic       entrada_ready,
    input  logic [7:0] endereco,
    input  logic       read,
    output logic [7:0] dado_out,
    output logic       dado_disponivel
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          udf;

    logic          full;
    logic          push;
    logic          pop;
    logic          ovf_evt;
    logic          udf_evt;
    logic          rd_dado;
    logic          rd_status;
    logic [7:0]    status_byte;

    // Ready and status derive only from registered state, never from same-cycle pops.
    assign full            = (count == CW'(DEPTH));
    assign entrada_ready   = !full;
    assign dado_disponivel = (count != '0);

    assign rd_dado     = read && (endereco == ADDR_DADO);
    assign rd_status   = read && (endereco == ADDR_STATUS);
    assign push        = entrada_valid && entrada_ready;
    assign ovf_evt     = entrada_valid && full;
    assign pop         = rd_dado && dado_disponivel;
    assign udf_evt     = rd_dado && !dado_disponivel;
    assign status_byte = {dado_disponivel, full, ovf, udf, 4'(count)};

    // Storage array is not reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= entrada;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            dado_out <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= PW'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= PW'(rd_ptr + 1'b1);
            end

            case ({push, pop})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase

            // A status read clears the sticky flags, but a coincident set event wins.
            ovf <= ovf_evt || (ovf && !rd_status);
            udf <= udf_evt || (udf && !rd_status);

            if (rd_dado) begin
                dado_out <= pop ? mem[rd_ptr] : 8'h00;
            end else if (rd_status) begin
                dado_out <= status_byte;
            end
        end
    end

endmodule

// File: tb/tb_porta_entrada.sv
// Scoreboard bench for porta_entrada: reads queue expected bytes, a monitor checks
// dado_out one cycle after each decoded read.
module tb_porta_entrada;

    localparam logic [7:0] A_DADO = 8'hF0;
    localparam logic [7:0] A_STAT = 8'hF1;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] entrada;
    logic       entrada_valid;
    logic       entrada_ready;
    logic [7:0] endereco;
    logic       read;
    logic [7:0] dado_out;
    logic       dado_disponivel;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q [$];
    logic [7:0] ref_q [$];

    porta_entrada #(.ADDR_DADO(A_DADO), .ADDR_STATUS(A_STAT), .DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .entrada         (entrada),
        .entrada_valid   (entrada_valid),
        .entrada_ready   (entrada_ready),
        .endereco        (endereco),
        .read            (read),
        .dado_out        (dado_out),
        .dado_disponivel (dado_disponivel)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs; when a read is issued, queue its expected byte.
    task automatic step(input logic v, input logic [7:0] d, input logic r,
                        input logic [7:0] a, input logic [7:0] exp);
        entrada_valid = v;
        entrada       = d;
        read          = r;
        endereco      = a;
        if (r && (a == A_DADO || a == A_STAT)) exp_q.push_back(exp);
        @(negedge clock);
    endtask

    task automatic push_b(input logic [7:0] d);
        ref_q.push_back(d);
        step(1'b1, d, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic status(input logic [7:0] exp);
        step(1'b0, 8'h00, 1'b1, A_STAT, exp);
    endtask

    task automatic pop_ref();
        logic [7:0] h;
        h = ref_q.pop_front();
        step(1'b0, 8'h00, 1'b1, A_DADO, h);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    // Monitor: one cycle after a decoded read, compare dado_out with the queue head.
    initial begin : monitor
        logic acc;
        logic [7:0] e;
        forever begin
            @(posedge clock);
            acc = !reset && read && (endereco == A_DADO || endereco == A_STAT);
            #1;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", dado_out, 8'hxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data", dado_out, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] h;
        reset = 1'b1; entrada_valid = 1'b1; entrada = 8'h55; read = 1'b0; endereco = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset_dado_out", dado_out, 8'h00);
        chk("reset_ready", {7'b0, entrada_ready}, 8'h01);
        chk("reset_disp", {7'b0, dado_disponivel}, 8'h00);
        status(8'h00);

        // Fill, check full, drain in order.
        push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h44);
        chk("full_ready", {7'b0, entrada_ready}, 8'h00);
        chk("full_disp", {7'b0, dado_disponivel}, 8'h01);
        status(8'hC4);
        pop_ref(); pop_ref(); pop_ref(); pop_ref();
        status(8'h00);

        // Overflow on a full FIFO; 8'h99 must never be read back.
        push_b(8'h01); push_b(8'h02); push_b(8'h03); push_b(8'h04);
        step(1'b1, 8'h99, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h99, 1'b0, 8'h00, 8'h00);
        status(8'hE4);
        status(8'hC4);
        pop_ref(); pop_ref(); pop_ref(); pop_ref();
        status(8'h00);

        // Underflow.
        step(1'b0, 8'h00, 1'b1, A_DADO, 8'h00);
        status(8'h10);
        status(8'h00);

        // Simultaneous push and pop at count 2, long enough to wrap pointers.
        push_b(8'h05); push_b(8'h06);
        for (int i = 0; i < 10; i++) begin
            h = ref_q.pop_front();
            ref_q.push_back(8'hAB + 8'(i));
            step(1'b1, 8'hAB + 8'(i), 1'b1, A_DADO, h);
        end
        status(8'h82);
        pop_ref(); pop_ref();

        // Push plus pop when empty: underflow, byte still stored.
        step(1'b1, 8'h5A, 1'b1, A_DADO, 8'h00);
        step(1'b0, 8'h00, 1'b1, A_DADO, 8'h5A);
        status(8'h10);

        // Push plus pop when full: pop succeeds, push refused and flagged.
        push_b(8'hC0); push_b(8'hC1); push_b(8'hC2); push_b(8'hC3);
        h = ref_q.pop_front();
        step(1'b1, 8'hEE, 1'b1, A_DADO, h);
        status(8'hA3);
        pop_ref(); pop_ref(); pop_ref();

        // Address decode: non-matching or idle accesses leave dado_out and count alone.
        push_b(8'h77);
        step(1'b0, 8'h00, 1'b1, 8'hE0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 8'h80, 8'h00);
        step(1'b0, 8'h00, 1'b0, A_DADO, 8'h00);
        chk("decode_hold", dado_out, 8'hC3);
        status(8'h81);
        pop_ref();
        idle();
        idle();

        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
